// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter/sequencer for the shared data memory with bounded locked ownership.
// Define ARB_RR_EN for round-robin conflict resolution; fixed m0 priority otherwise.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_we,
    input  logic              m1_we,
    input  logic              m0_lock,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_read_flag,
    output logic              mem_write_flag,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t state, state_nx;
    logic [CW-1:0] lock_cnt, cnt_inc, cnt_nx;
    logic rr_last, pick1, win1, gnt, we, lock, forced, keep;
    logic [1:0] rv_q;
`ifdef ARB_RR_EN
    // rr_last already names the released owner, so round robin hands off naturally
    assign pick1 = ~rr_last;
`else
    logic handoff;
    always_ff @(posedge clk) handoff <= ~rst & forced;
    assign pick1 = handoff & ~rr_last;
`endif
    always_comb begin
        win1 = state == OWN1 || (state == IDLE && m1_req && (!m0_req || pick1));
        gnt = ~rst & (win1 ? m1_req : m0_req);
        we = win1 ? m1_we : m0_we;
        lock = win1 ? m1_lock : m0_lock;
        m0_gnt = gnt & ~win1;
        m1_gnt = gnt & win1;
        mem_read_flag = gnt & ~we;
        mem_write_flag = gnt & we;
        mem_addr = gnt ? (win1 ? m1_addr : m0_addr) : '0;
        mem_write_data = gnt ? (win1 ? m1_wdata : m0_wdata) : '0;
        cnt_inc = state == IDLE ? CW'(1) : lock_cnt + CW'(1);
        forced = gnt & lock & (cnt_inc == CW'(LOCK_MAX));
        keep = gnt & lock & ~forced;
        state_nx = keep ? (win1 ? OWN1 : OWN0) : IDLE;
        cnt_nx = keep ? cnt_inc : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lock_cnt <= '0;
            rr_last <= 1'b1;
            rv_q <= '0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            state <= state_nx;
            lock_cnt <= cnt_nx;
            rv_q <= {m1_gnt & ~m1_we, m0_gnt & ~m0_we};
            if (gnt) rr_last <= win1;
            if (m0_gnt && !m0_we) m0_rdata <= mem_read_data;
            if (m1_gnt && !m1_we) m1_rdata <= mem_read_data;
        end
    end
    assign m0_rvalid = rv_q[0] & ~rst;
    assign m1_rvalid = rv_q[1] & ~rst;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a per-cycle behavioural model of the arbiter and a shared memory.
module tb_dmem_arbiter;
    localparam int LOCK_MAX = 8;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic req[2], we[2], lk[2];
    logic [31:0] addr[2], wd[2];
    logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_read_flag, mem_write_flag;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_write_data, mem_read_data;
    logic [31:0] mem[256];
    logic [31:0] mmem[256];
    int checks = 0, failures = 0;
    int own = -1, cnt = 0, last = 1;
    bit ho = 0;
    bit erv[2];
    logic [31:0] erd[2];

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m1_req(req[1]), .m0_we(we[0]), .m1_we(we[1]),
        .m0_lock(lk[0]), .m1_lock(lk[1]), .m0_addr(addr[0]), .m1_addr(addr[1]),
        .m0_wdata(wd[0]), .m1_wdata(wd[1]), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_write_flag) mem[mem_addr[9:2]] <= mem_write_data;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // Model: who wins this cycle, then what the memory and read-return must look like.
    always @(negedge clk) begin
        int w;
        if (rst) w = -1;
        else if (own >= 0) w = req[own] ? own : -1;
        else if (req[0] && req[1]) w = (RR || ho) ? 1 - last : 0;
        else w = req[0] ? 0 : (req[1] ? 1 : -1);
        chk("gnt0", 32'(m0_gnt), 32'(w == 0));
        chk("gnt1", 32'(m1_gnt), 32'(w == 1));
        chk("rflag", 32'(mem_read_flag), 32'(w >= 0 && !we[w >= 0 ? w : 0]));
        chk("wflag", 32'(mem_write_flag), 32'(w >= 0 && we[w >= 0 ? w : 0]));
        chk("maddr", mem_addr, w >= 0 ? addr[w] : 32'h0);
        chk("mwdata", mem_write_data, w >= 0 ? wd[w] : 32'h0);
        chk("rvalid0", 32'(m0_rvalid), 32'(!rst && erv[0]));
        chk("rvalid1", 32'(m1_rvalid), 32'(!rst && erv[1]));
        if (!rst) begin
            chk("rdata0", m0_rdata, erd[0]);
            chk("rdata1", m1_rdata, erd[1]);
        end
        if (rst) begin
            own = -1; cnt = 0; last = 1; ho = 0;
            erv = '{0, 0}; erd = '{32'h0, 32'h0};
        end else begin
            erv = '{0, 0};
            ho = 0;
            if (w >= 0) begin
                if (we[w]) mmem[addr[w][9:2]] = wd[w];
                else begin
                    erv[w] = 1;
                    erd[w] = mmem[addr[w][9:2]];
                end
                last = w;
                if (lk[w]) begin
                    cnt = own < 0 ? 1 : cnt + 1;
                    if (cnt == LOCK_MAX) begin
                        own = -1; cnt = 0; ho = 1;
                    end else own = w;
                end else begin
                    own = -1; cnt = 0;
                end
            end else begin
                own = -1; cnt = 0;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            req[i] = 0; we[i] = 0; lk[i] = 0; addr[i] = 0; wd[i] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        nxt();
        rst = 0;
    endtask

    initial begin
        logic [3:0] g0, g1;
        int n0, first;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 0;
            mmem[i] = 0;
        end
        idle();
        nxt();
        nxt();
        rst = 0;
        // no requests: everything quiet
        @(negedge clk);
        chk("t6_gnt0", 32'(m0_gnt), 0);
        chk("t6_gnt1", 32'(m1_gnt), 0);
        chk("t6_rflag", 32'(mem_read_flag), 0);
        chk("t6_wflag", 32'(mem_write_flag), 0);
        chk("t6_addr", mem_addr, 0);
        // simultaneous unlocked requests
        nxt();
        req[0] = 1; req[1] = 1; addr[0] = 32'h4; addr[1] = 32'h8;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            g0[i] = m0_gnt;
            g1[i] = m1_gnt;
            nxt();
        end
        chk("t2_m0_seq", 32'(g0), RR ? 32'h5 : 32'hF);
        chk("t2_m1_seq", 32'(g1), RR ? 32'hA : 32'h0);
        // write then read back
        do_reset();
        req[0] = 1; we[0] = 1; addr[0] = 32'h10; wd[0] = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_wgnt", 32'(m0_gnt), 1);
        nxt();
        we[0] = 0;
        @(negedge clk);
        chk("t1_rgnt", 32'(m0_gnt), 1);
        nxt();
        req[0] = 0;
        @(negedge clk);
        chk("t1_rvalid", 32'(m0_rvalid), 1);
        chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
        nxt();
        @(negedge clk);
        chk("t1_rvalid_pulse", 32'(m0_rvalid), 0);
        // m1 locked sequence holds off m0
        do_reset();
        req[1] = 1; lk[1] = 1; we[1] = 1; addr[1] = 32'h40; wd[1] = 32'h11;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) lk[1] = 0;
            @(negedge clk);
            chk("t3_m1_gnt", 32'(m1_gnt), 1);
            chk("t3_m0_stall", 32'(m0_gnt), 0);
            nxt();
            if (i == 0) begin
                req[0] = 1; we[0] = 0; addr[0] = 32'h40;
            end
        end
        req[1] = 0;
        @(negedge clk);
        chk("t3_m0_after", 32'(m0_gnt), 1);
        nxt();
        req[0] = 0;
        nxt();
        // lock held past the limit forces a handoff to the waiting master
        do_reset();
        req[0] = 1; lk[0] = 1; we[0] = 1; addr[0] = 32'h80; wd[0] = 32'h5A5A;
        req[1] = 1; we[1] = 0; addr[1] = 32'h10;
        n0 = 0;
        first = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m1_gnt) begin
                first = i;
                break;
            end
            if (m0_gnt) n0++;
            nxt();
        end
        chk("t4_m0_grants", n0, 8);
        chk("t4_m1_cycle", first, 8);
        nxt();
        idle();
        nxt();
        // reset right after a granted read
        do_reset();
        req[0] = 1; addr[0] = 32'h10;
        @(negedge clk);
        chk("t5_gnt", 32'(m0_gnt), 1);
        nxt();
        rst = 1;
        @(negedge clk);
        chk("t5_rvalid_in_rst", 32'(m0_rvalid), 0);
        chk("t5_gnt_in_rst", 32'(m0_gnt), 0);
        nxt();
        rst = 0;
        req[0] = 0;
        @(negedge clk);
        chk("t5_rvalid", 32'(m0_rvalid), 0);
        chk("t5_rdata", m0_rdata, 0);
        nxt();
        nxt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
